// File: rtl/slave_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : slave_write_arbiter
// Description : Per-slave write-path scheduler. Round-robin arbitrates the
//               master AW FIFO fronts that decode to this slave and records
//               the AW grant order in a small queue. The W channel is locked
//               to the master at the queue head until its WLAST beat moves.
// Revision    : 1.0 - initial release
// ============================================================================
module slave_write_arbiter #(
    parameter int masters           = 2,
    parameter int slaves            = 2,
    parameter int i_am_slave_number = 0,
    parameter int pending_depth     = 8,
    localparam int MW = (masters > 1) ? $clog2(masters) : 1,
    localparam int SW = (slaves > 1) ? $clog2(slaves) : 1,
    localparam int CW = $clog2(pending_depth + 1)
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [masters-1:0]    master_write_addr_fifo_empty,
    input  logic [masters*SW-1:0] write_addr_forward_dest_slave,
    input  logic                  slave_write_addr_fifo_full,
    input  logic [masters-1:0]    master_write_data_fifo_empty,
    input  logic [masters-1:0]    master_wlast,
    input  logic                  slave_write_data_fifo_full,
    output logic                  aw_grant,
    output logic [MW-1:0]         aw_grant_master,
    output logic [masters-1:0]    aw_pop,
    output logic                  w_grant,
    output logic [MW-1:0]         w_grant_master,
    output logic [masters-1:0]    w_pop,
    output logic [CW-1:0]         outstanding_writes
);

    localparam int          PW      = $clog2(pending_depth);
    localparam logic [MW:0] c_M     = (MW + 1)'(masters);
    localparam logic [CW-1:0] c_DEPTH = CW'(pending_depth);

    // Arbitration and order-queue state
    logic [MW-1:0] rr_ptr_q, rr_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [MW-1:0] queue_q [pending_depth];

    logic [masters-1:0]   w_req;
    logic [2*masters-1:0] w_req2;
    logic                 w_found;
    logic [MW-1:0]        w_offset;
    logic [MW:0]          w_sum;
    logic [MW:0]          w_next_sum;
    logic [MW-1:0]        w_winner;
    logic [MW-1:0]        w_head;
    logic                 w_queue_nonempty;
    logic                 w_push;
    logic                 w_pop_q;

    // A master requests when its AW front is valid and decodes to this slave
    generate
        for (genvar m = 0; m < masters; m++) begin : g_req
            assign w_req[m] = ~master_write_addr_fifo_empty[m] &
                (write_addr_forward_dest_slave[m*SW +: SW] == SW'(i_am_slave_number));
        end
    endgenerate

    // Rotate requests so bit 0 is the master at rr_ptr; first set bit wins
    assign w_req2 = {w_req, w_req} >> rr_ptr_q;

    // Find the first requester at or after the round-robin pointer
    always_comb begin
        w_found  = 1'b0;
        w_offset = '0;
        for (int i = 0; i < masters; i++) begin
            if (!w_found && w_req2[i]) begin
                w_found  = 1'b1;
                w_offset = MW'(i);
            end
        end
        w_sum = {1'b0, rr_ptr_q} + {1'b0, w_offset};
        if (w_sum >= c_M) begin
            w_sum = w_sum - c_M;
        end
        w_winner   = w_sum[MW-1:0];
        w_next_sum = {1'b0, w_winner} + {{MW{1'b0}}, 1'b1};
        if (w_next_sum >= c_M) begin
            w_next_sum = '0;
        end
    end

    // A full queue blocks new AW grants even if the head pops this cycle
    assign aw_grant        = w_found & ~slave_write_addr_fifo_full & (count_q < c_DEPTH);
    assign aw_grant_master = w_winner;
    assign aw_pop          = (masters'(1) << w_winner) & {masters{aw_grant}};
    assign w_push          = aw_grant;

    // W is served only from the registered queue head, never from this cycle's AW
    assign w_queue_nonempty = (count_q != '0);
    assign w_head           = w_queue_nonempty ? queue_q[rd_ptr_q] : '0;
    assign w_grant          = w_queue_nonempty & ~master_write_data_fifo_empty[w_head] &
                              ~slave_write_data_fifo_full;
    assign w_grant_master   = w_head;
    assign w_pop            = (masters'(1) << w_head) & {masters{w_grant}};
    assign w_pop_q          = w_grant & master_wlast[w_head];

    assign outstanding_writes = count_q;

    // Next-state for pointers and occupancy
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            rr_ptr_d = w_next_sum[MW-1:0];
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop_q) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop_q})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Control registers; reset flushes the queue and drops any in-flight transfer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rr_ptr_q <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Order-queue storage; contents are only meaningful below count_q
    always_ff @(posedge ACLK) begin
        if (!ARESET && w_push) begin
            queue_q[wr_ptr_q] <= w_winner;
        end
    end

    // Queue underflow/overflow must never happen
    always_ff @(posedge ACLK) begin
        if (!ARESET) begin
            assert (!(w_pop_q && (count_q == '0)));
            assert (!(w_push && (count_q == c_DEPTH)));
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_slave_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_slave_write_arbiter
// Description : Directed self-checking bench. Three instances share stimulus:
//               a = slave 0 depth 8, b = slave 1 depth 8, c = slave 0 depth 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_slave_write_arbiter;

    logic       ACLK = 1'b0;
    logic       ARESET;
    logic [1:0] aw_empty, dest, w_empty, wlast;
    logic       aw_full, w_full;

    logic       aw_grant_a, aw_grant_b, aw_grant_c;
    logic [0:0] aw_master_a, aw_master_b, aw_master_c;
    logic [1:0] aw_pop_a, aw_pop_b, aw_pop_c;
    logic       w_grant_a, w_grant_b, w_grant_c;
    logic [0:0] w_master_a, w_master_b, w_master_c;
    logic [1:0] w_pop_a, w_pop_b, w_pop_c;
    logic [3:0] outst_a, outst_b;
    logic [1:0] outst_c;

    int tests  = 0;
    int failed = 0;

    always #5 ACLK = ~ACLK;

    slave_write_arbiter #(.masters(2), .slaves(2), .i_am_slave_number(0), .pending_depth(8)) dut_a (
        .ACLK(ACLK), .ARESET(ARESET),
        .master_write_addr_fifo_empty(aw_empty), .write_addr_forward_dest_slave(dest),
        .slave_write_addr_fifo_full(aw_full), .master_write_data_fifo_empty(w_empty),
        .master_wlast(wlast), .slave_write_data_fifo_full(w_full),
        .aw_grant(aw_grant_a), .aw_grant_master(aw_master_a), .aw_pop(aw_pop_a),
        .w_grant(w_grant_a), .w_grant_master(w_master_a), .w_pop(w_pop_a),
        .outstanding_writes(outst_a));

    slave_write_arbiter #(.masters(2), .slaves(2), .i_am_slave_number(1), .pending_depth(8)) dut_b (
        .ACLK(ACLK), .ARESET(ARESET),
        .master_write_addr_fifo_empty(aw_empty), .write_addr_forward_dest_slave(dest),
        .slave_write_addr_fifo_full(aw_full), .master_write_data_fifo_empty(w_empty),
        .master_wlast(wlast), .slave_write_data_fifo_full(w_full),
        .aw_grant(aw_grant_b), .aw_grant_master(aw_master_b), .aw_pop(aw_pop_b),
        .w_grant(w_grant_b), .w_grant_master(w_master_b), .w_pop(w_pop_b),
        .outstanding_writes(outst_b));

    slave_write_arbiter #(.masters(2), .slaves(2), .i_am_slave_number(0), .pending_depth(2)) dut_c (
        .ACLK(ACLK), .ARESET(ARESET),
        .master_write_addr_fifo_empty(aw_empty), .write_addr_forward_dest_slave(dest),
        .slave_write_addr_fifo_full(aw_full), .master_write_data_fifo_empty(w_empty),
        .master_wlast(wlast), .slave_write_data_fifo_full(w_full),
        .aw_grant(aw_grant_c), .aw_grant_master(aw_master_c), .aw_pop(aw_pop_c),
        .w_grant(w_grant_c), .w_grant_master(w_master_c), .w_pop(w_pop_c),
        .outstanding_writes(outst_c));

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic idle_inputs();
        aw_empty = 2'b11; dest = 2'b00; w_empty = 2'b11; wlast = 2'b00;
        aw_full  = 1'b0;  w_full = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (aw_grant_a !== 1'b0) begin failed++; $display("FAIL reset_aw_grant got=%0h exp=0", aw_grant_a); end
        tests++; if (w_grant_a !== 1'b0) begin failed++; $display("FAIL reset_w_grant got=%0h exp=0", w_grant_a); end
        tests++; if (aw_pop_a !== 2'b00 || w_pop_a !== 2'b00) begin failed++; $display("FAIL reset_pops got=%0h/%0h exp=0/0", aw_pop_a, w_pop_a); end
        tests++; if (aw_master_a !== 1'b0 || w_master_a !== 1'b0) begin failed++; $display("FAIL reset_masters got=%0h/%0h exp=0/0", aw_master_a, w_master_a); end
        tests++; if (outst_a !== 4'd0) begin failed++; $display("FAIL reset_outstanding got=%0d exp=0", outst_a); end
    endtask

    task automatic test_round_robin();
        logic [0:0] exp_m;
        logic [1:0] exp_pop;
        do_reset();
        aw_empty = 2'b00; dest = 2'b00;
        for (int i = 0; i < 4; i++) begin
            exp_m   = (i % 2 == 0) ? 1'b0 : 1'b1;
            exp_pop = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            tests++; if (aw_grant_a !== 1'b1) begin failed++; $display("FAIL rr_grant[%0d] got=%0h exp=1", i, aw_grant_a); end
            tests++; if (aw_master_a !== exp_m) begin failed++; $display("FAIL rr_master[%0d] got=%0h exp=%0h", i, aw_master_a, exp_m); end
            tests++; if (aw_pop_a !== exp_pop) begin failed++; $display("FAIL rr_pop[%0d] got=%0h exp=%0h", i, aw_pop_a, exp_pop); end
            tick();
        end
        tests++; if (outst_a !== 4'd4) begin failed++; $display("FAIL rr_outstanding got=%0d exp=4", outst_a); end
    endtask

    task automatic test_dest_filter();
        do_reset();
        aw_empty = 2'b00; dest = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (aw_grant_b !== 1'b1 || aw_master_b !== 1'b1) begin failed++; $display("FAIL dest_grant[%0d] got=%0h/%0h exp=1/1", i, aw_grant_b, aw_master_b); end
            tests++; if (aw_pop_b !== 2'b10) begin failed++; $display("FAIL dest_pop[%0d] got=%0h exp=2", i, aw_pop_b); end
            tick();
        end
        tests++; if (outst_b !== 4'd3) begin failed++; $display("FAIL dest_outstanding got=%0d exp=3", outst_b); end
        aw_empty = 2'b10; #1;
        tests++; if (aw_grant_b !== 1'b0) begin failed++; $display("FAIL dest_block_m0 got=%0h exp=0", aw_grant_b); end
    endtask

    task automatic test_w_ordering();
        do_reset();
        // AW from m1 while W data waits everywhere: no same-cycle W
        aw_empty = 2'b01; w_empty = 2'b00; #1;
        tests++; if (aw_grant_a !== 1'b1 || aw_master_a !== 1'b1) begin failed++; $display("FAIL ord_aw1 got=%0h/%0h exp=1/1", aw_grant_a, aw_master_a); end
        tests++; if (w_grant_a !== 1'b0) begin failed++; $display("FAIL ord_no_bypass got=%0h exp=0", w_grant_a); end
        tick();
        aw_empty = 2'b10; w_empty = 2'b11; #1;
        tests++; if (aw_grant_a !== 1'b1 || aw_master_a !== 1'b0) begin failed++; $display("FAIL ord_aw2 got=%0h/%0h exp=1/0", aw_grant_a, aw_master_a); end
        tick();
        aw_empty = 2'b11; w_empty = 2'b10; #1;
        tests++; if (outst_a !== 4'd2) begin failed++; $display("FAIL ord_outstanding2 got=%0d exp=2", outst_a); end
        tests++; if (w_grant_a !== 1'b0 || w_master_a !== 1'b1 || w_pop_a !== 2'b00) begin failed++; $display("FAIL ord_wait_m1 got=%0h/%0h/%0h exp=0/1/0", w_grant_a, w_master_a, w_pop_a); end
        tick();
        w_empty = 2'b00;
        for (int b = 0; b < 4; b++) begin
            wlast = (b == 3) ? 2'b10 : 2'b00; #1;
            tests++; if (w_grant_a !== 1'b1 || w_pop_a !== 2'b10) begin failed++; $display("FAIL ord_m1_beat[%0d] got=%0h/%0h exp=1/2", b, w_grant_a, w_pop_a); end
            tick();
        end
        tests++; if (outst_a !== 4'd1 || w_master_a !== 1'b0) begin failed++; $display("FAIL ord_after_m1 got=%0d/%0h exp=1/0", outst_a, w_master_a); end
        for (int b = 0; b < 2; b++) begin
            wlast = (b == 1) ? 2'b01 : 2'b00; #1;
            tests++; if (w_grant_a !== 1'b1 || w_pop_a !== 2'b01) begin failed++; $display("FAIL ord_m0_beat[%0d] got=%0h/%0h exp=1/1", b, w_grant_a, w_pop_a); end
            tick();
        end
        tests++; if (outst_a !== 4'd0 || w_grant_a !== 1'b0) begin failed++; $display("FAIL ord_drained got=%0d/%0h exp=0/0", outst_a, w_grant_a); end
    endtask

    task automatic test_backpressure();
        do_reset();
        aw_empty = 2'b10; tick();
        aw_empty = 2'b11; w_empty = 2'b00; wlast = 2'b00; #1;
        tests++; if (w_grant_a !== 1'b1) begin failed++; $display("FAIL bp_beat0 got=%0h exp=1", w_grant_a); end
        tick();
        w_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            tests++; if (w_grant_a !== 1'b0 || w_pop_a !== 2'b00 || w_master_a !== 1'b0) begin failed++; $display("FAIL bp_stall[%0d] got=%0h/%0h/%0h exp=0/0/0", i, w_grant_a, w_pop_a, w_master_a); end
            tick();
        end
        w_full = 1'b0; #1;
        tests++; if (w_grant_a !== 1'b1 || outst_a !== 4'd1) begin failed++; $display("FAIL bp_resume got=%0h/%0d exp=1/1", w_grant_a, outst_a); end
        tick();
        wlast = 2'b01; #1;
        tests++; if (w_grant_a !== 1'b1 || w_pop_a !== 2'b01) begin failed++; $display("FAIL bp_last got=%0h/%0h exp=1/1", w_grant_a, w_pop_a); end
        tick();
        tests++; if (outst_a !== 4'd0) begin failed++; $display("FAIL bp_drained got=%0d exp=0", outst_a); end
    endtask

    task automatic test_queue_full();
        do_reset();
        aw_empty = 2'b00; #1;
        tests++; if (aw_grant_c !== 1'b1 || aw_master_c !== 1'b0) begin failed++; $display("FAIL qf_aw1 got=%0h/%0h exp=1/0", aw_grant_c, aw_master_c); end
        tick();
        tests++; if (aw_grant_c !== 1'b1 || aw_master_c !== 1'b1) begin failed++; $display("FAIL qf_aw2 got=%0h/%0h exp=1/1", aw_grant_c, aw_master_c); end
        tick();
        tests++; if (outst_c !== 2'd2 || aw_grant_c !== 1'b0) begin failed++; $display("FAIL qf_full got=%0d/%0h exp=2/0", outst_c, aw_grant_c); end
        w_empty = 2'b00; wlast = 2'b01; #1;
        tests++; if (w_grant_c !== 1'b1 || aw_grant_c !== 1'b0) begin failed++; $display("FAIL qf_pop_same_cycle got=%0h/%0h exp=1/0", w_grant_c, aw_grant_c); end
        tick();
        w_empty = 2'b11; wlast = 2'b00; #1;
        tests++; if (aw_grant_c !== 1'b1 || aw_master_c !== 1'b0 || outst_c !== 2'd1) begin failed++; $display("FAIL qf_aw3 got=%0h/%0h/%0d exp=1/0/1", aw_grant_c, aw_master_c, outst_c); end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        aw_empty = 2'b10; tick();
        aw_empty = 2'b11; w_empty = 2'b00; wlast = 2'b00;
        tick(); tick();
        ARESET = 1'b1; tick();
        ARESET = 1'b0; #1;
        tests++; if (outst_a !== 4'd0 || w_grant_a !== 1'b0) begin failed++; $display("FAIL rmb_flush got=%0d/%0h exp=0/0", outst_a, w_grant_a); end
        w_empty = 2'b11; aw_empty = 2'b00; #1;
        tests++; if (aw_grant_a !== 1'b1 || aw_master_a !== 1'b0) begin failed++; $display("FAIL rmb_rr_reset got=%0h/%0h exp=1/0", aw_grant_a, aw_master_a); end
        tick();
    endtask

    initial begin
        idle_inputs();
        ARESET = 1'b1;
        test_reset();
        test_round_robin();
        test_dest_filter();
        test_w_ordering();
        test_backpressure();
        test_queue_full();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
